// File: rtl/dm.sv
// Shared debug-module definitions used on the DTM side of the DMI link.
package dm;

    // Operation field of a DMIACCESS scan (host -> DTM).
    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    // Status returned in the op field at Capture-DR (DTM -> host).
    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'h0,
        DTM_ERR     = 2'h2,
        DTM_BUSY    = 2'h3
    } dtm_op_status_e;

    // Layout of the DTMCS register.
    typedef struct packed {
        logic [31:18] zero1;
        logic         dmihardreset;
        logic         dmireset;
        logic         zero0;
        logic [14:12] idle;
        logic [11:10] dmistat;
        logic [9:4]   abits;
        logic [3:0]   version;
    } dtmcs_t;

    // DMI request as seen by the debug module.
    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    // DMI response from the debug module.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // Response code the debug module uses for a successful access.
    localparam logic [1:0] DMI_RESP_OK = 2'h0;

endpackage

// File: rtl/dmi_access_ctrl.sv
// DTM-side DMI access controller (TCK domain). Turns DMIACCESS Update-DR
// scans into valid/ready DMI requests, collects responses, tracks the
// sticky busy/error status and supplies the Capture-DR word.
module dmi_access_ctrl
    import dm::*;
#(
    parameter int unsigned AddrWidth     = 7,
    parameter logic [2:0]  DmiIdleCycles = 3'd1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   dmi_select_i,
    input  logic                   capture_dr_i,
    input  logic                   update_dr_i,
    input  logic [AddrWidth+33:0]  dr_i,
    input  logic                   dmireset_i,
    input  logic                   dmihardreset_i,
    output logic [AddrWidth+33:0]  capture_o,
    output logic [1:0]             dmistat_o,
    output logic [2:0]             idle_o,
    output logic                   dmi_req_valid_o,
    input  logic                   dmi_req_ready_i,
    output logic [AddrWidth-1:0]   dmi_req_addr_o,
    output logic [1:0]             dmi_req_op_o,
    output logic [31:0]            dmi_req_data_o,
    input  logic                   dmi_resp_valid_i,
    output logic                   dmi_resp_ready_o,
    input  logic [31:0]            dmi_resp_data_i,
    input  logic [1:0]             dmi_resp_resp_i
);

    localparam int unsigned DmiWidth = AddrWidth + 34;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ       = 3'd1,
        WAIT_READ  = 3'd2,
        WRITE      = 3'd3,
        WAIT_WRITE = 3'd4
    } state_e;

    state_e                r_state;
    logic                  r_req_valid;
    logic                  r_resp_ready;
    logic [AddrWidth-1:0]  r_addr;
    logic [31:0]           r_data;
    dtm_op_e               r_req_op;
    dtm_op_status_e        r_error;
    logic [DmiWidth-1:0]   r_capture;

    logic [AddrWidth-1:0]  w_dr_addr;
    logic [31:0]           w_dr_data;
    dtm_op_e               w_dr_op;
    logic                  w_dmi_event;
    logic                  w_busy_hit;
    logic                  w_waiting;
    logic                  w_resp_err;
    logic                  w_start;
    dtm_op_status_e        w_error_d;
    dtm_op_status_e        w_cap_op;

    // Split the shifted DR word into its fields.
    assign w_dr_addr = dr_i[DmiWidth-1:34];
    assign w_dr_data = dr_i[33:2];
    assign w_dr_op   = dtm_op_e'(dr_i[1:0]);

    // Any DMIACCESS capture/update while a transaction is in flight is a busy hit.
    assign w_dmi_event = dmi_select_i & (update_dr_i | capture_dr_i);
    assign w_busy_hit  = w_dmi_event & (r_state != IDLE);
    assign w_waiting   = (r_state == WAIT_READ) | (r_state == WAIT_WRITE);
    assign w_resp_err  = w_waiting & dmi_resp_valid_i & (dmi_resp_resp_i != DMI_RESP_OK);
    assign w_start     = dmi_select_i & update_dr_i & (r_state == IDLE) &
                         (r_error == DTM_SUCCESS);

    // Next sticky error: dmireset clears first, otherwise the first error sticks.
    always_comb begin
        w_error_d = r_error;
        if (dmireset_i) begin
            w_error_d = DTM_SUCCESS;
        end else if (r_error != DTM_SUCCESS) begin
            w_error_d = r_error;
        end else if (w_busy_hit) begin
            w_error_d = DTM_BUSY;
        end else if (w_resp_err) begin
            w_error_d = DTM_ERR;
        end else begin
            w_error_d = r_error;
        end
    end

    // Op field presented to the host: busy overrides a clean status while in flight.
    always_comb begin
        w_cap_op = r_error;
        if ((r_state != IDLE) && (r_error == DTM_SUCCESS)) begin
            w_cap_op = DTM_BUSY;
        end else begin
            w_cap_op = r_error;
        end
    end

    // Request/response FSM with registered handshake outputs and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_addr       <= '0;
            r_data       <= 32'h0000_0000;
            r_req_op     <= DTM_NOP;
            r_error      <= DTM_SUCCESS;
        end else if (dmihardreset_i) begin
            // Abandon any transaction; a late response then lands in IDLE and is dropped.
            r_state      <= IDLE;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_error      <= DTM_SUCCESS;
        end else begin
            r_error <= w_error_d;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        case (w_dr_op)
                            DTM_READ: begin
                                r_addr      <= w_dr_addr;
                                r_req_op    <= DTM_READ;
                                r_req_valid <= 1'b1;
                                r_state     <= READ;
                            end
                            DTM_WRITE: begin
                                r_addr      <= w_dr_addr;
                                r_data      <= w_dr_data;
                                r_req_op    <= DTM_WRITE;
                                r_req_valid <= 1'b1;
                                r_state     <= WRITE;
                            end
                            default: begin
                                r_state <= IDLE;
                            end
                        endcase
                    end else begin
                        r_state <= IDLE;
                    end
                end
                READ: begin
                    if (dmi_req_ready_i) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_state      <= WAIT_READ;
                    end else begin
                        r_state <= READ;
                    end
                end
                WRITE: begin
                    if (dmi_req_ready_i) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_state      <= WAIT_WRITE;
                    end else begin
                        r_state <= WRITE;
                    end
                end
                WAIT_READ: begin
                    if (dmi_resp_valid_i) begin
                        r_data       <= dmi_resp_data_i;
                        r_resp_ready <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_state <= WAIT_READ;
                    end
                end
                WAIT_WRITE: begin
                    if (dmi_resp_valid_i) begin
                        r_resp_ready <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_state <= WAIT_WRITE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_valid  <= 1'b0;
                    r_resp_ready <= 1'b0;
                end
            endcase
        end
    end

    // Capture word, refreshed every edge so Capture-DR sees the previous edge's state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_capture <= '0;
        end else begin
            r_capture <= {r_addr, r_data, w_cap_op};
        end
    end

    assign capture_o        = r_capture;
    assign dmistat_o        = r_error;
    assign idle_o           = DmiIdleCycles;
    assign dmi_req_valid_o  = r_req_valid;
    assign dmi_req_addr_o   = r_addr;
    assign dmi_req_op_o     = r_req_op;
    assign dmi_req_data_o   = r_data;
    assign dmi_resp_ready_o = r_resp_ready;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Scoreboard bench for dmi_access_ctrl: stimulus pushes expected DMI
// requests, a monitor compares every presented request against the queue.
module tb_dmi_access_ctrl;
    import dm::*;

    localparam int AW = 7;
    localparam int DW = AW + 34;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          dmi_select_i;
    logic          capture_dr_i;
    logic          update_dr_i;
    logic [DW-1:0] dr_i;
    logic          dmireset_i;
    logic          dmihardreset_i;
    logic [DW-1:0] capture_o;
    logic [1:0]    dmistat_o;
    logic [2:0]    idle_o;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i;
    logic [AW-1:0] dmi_req_addr_o;
    logic [1:0]    dmi_req_op_o;
    logic [31:0]   dmi_req_data_o;
    logic          dmi_resp_valid_i;
    logic          dmi_resp_ready_o;
    logic [31:0]   dmi_resp_data_i;
    logic [1:0]    dmi_resp_resp_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    op;
        logic [31:0]   data;
        bit            chk_data;
    } req_exp_t;

    req_exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmi_access_ctrl #(.AddrWidth(AW), .DmiIdleCycles(3'd1)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .dmi_select_i     (dmi_select_i),
        .capture_dr_i     (capture_dr_i),
        .update_dr_i      (update_dr_i),
        .dr_i             (dr_i),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .capture_o        (capture_o),
        .dmistat_o        (dmistat_o),
        .idle_o           (idle_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_resp_i  (dmi_resp_resp_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [AW-1:0] addr, input logic [1:0] op,
                            input logic [31:0] data, input bit chk_data);
        req_exp_t e;
        e.addr = addr; e.op = op; e.data = data; e.chk_data = chk_data;
        exp_q.push_back(e);
    endtask

    task automatic do_update(input logic [AW-1:0] addr, input logic [31:0] data, input logic [1:0] op);
        dr_i        = {addr, data, op};
        update_dr_i = 1'b1;
        tick();
        update_dr_i = 1'b0;
    endtask

    task automatic capture_check(input string name, input logic [AW-1:0] addr,
                                 input logic [31:0] data, input logic [1:0] op);
        logic [DW-1:0] exp_word;
        exp_word     = {addr, data, op};
        capture_dr_i = 1'b1;
        check(name, capture_o, exp_word);
        tick();
        capture_dr_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic [1:0] resp);
        int n;
        n = 0;
        while (!dmi_resp_ready_o && n < 20) begin
            tick();
            n++;
        end
        check("resp_ready_before_resp", dmi_resp_ready_o, 1'b1);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = data;
        dmi_resp_resp_i  = resp;
        tick();
        dmi_resp_valid_i = 1'b0;
        dmi_resp_resp_i  = 2'd0;
    endtask

    task automatic pulse_dmireset();
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
    endtask

    // Monitor: every cycle a request is presented, compare it with the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i && dmi_req_valid_o) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_req: got addr 0x%0h op %0d data 0x%0h, expected no request",
                             dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o);
                end else begin
                    if (dmi_req_addr_o !== exp_q[0].addr || dmi_req_op_o !== exp_q[0].op ||
                        (exp_q[0].chk_data && dmi_req_data_o !== exp_q[0].data)) begin
                        n_fail++;
                        $display("FAIL req_fields: got addr 0x%0h op %0d data 0x%0h, expected addr 0x%0h op %0d data 0x%0h",
                                 dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
                                 exp_q[0].addr, exp_q[0].op, exp_q[0].data);
                    end
                    if (dmi_req_ready_i) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst_i = 1'b1; dmi_select_i = 1'b0; capture_dr_i = 1'b0; update_dr_i = 1'b0;
        dr_i = '0; dmireset_i = 1'b0; dmihardreset_i = 1'b0; dmi_req_ready_i = 1'b0;
        dmi_resp_valid_i = 1'b0; dmi_resp_data_i = 32'h0; dmi_resp_resp_i = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", dmi_req_valid_o, 1'b0);
        check("reset_dmistat", dmistat_o, 2'd0);
        check("reset_capture", capture_o, 64'h0);
        check("reset_resp_ready", dmi_resp_ready_o, 1'b0);
        check("reset_addr_data", {dmi_req_addr_o, dmi_req_data_o}, 64'h0);
        check("idle_field", idle_o, 3'd1);
        rst_i = 1'b0;
        tick();
        dmi_select_i = 1'b1;

        // Write 0x10 / 0x8000_0001, ready high, ok response next cycle.
        dmi_req_ready_i = 1'b1;
        push_req(7'h10, 2'd2, 32'h8000_0001, 1'b1);
        do_update(7'h10, 32'h8000_0001, 2'd2);
        check("write_valid_latency", dmi_req_valid_o, 1'b1);
        tick();
        respond(32'h0, 2'd0);
        check("write_dmistat", dmistat_o, 2'd0);
        tick(); tick();
        capture_check("write_capture", 7'h10, 32'h8000_0001, 2'd0);

        // Read 0x11 with ready held off for 4 cycles.
        dmi_req_ready_i = 1'b0;
        push_req(7'h11, 2'd1, 32'h0, 1'b0);
        do_update(7'h11, 32'h0, 2'd1);
        for (int i = 0; i < 4; i++) begin
            check("read_valid_held", dmi_req_valid_o, 1'b1);
            tick();
        end
        dmi_req_ready_i = 1'b1;
        check("read_valid_at_ready", dmi_req_valid_o, 1'b1);
        tick();
        check("read_valid_dropped", dmi_req_valid_o, 1'b0);
        respond(32'hDEAD_BEEF, 2'd0);
        tick(); tick();
        check("read_dmistat", dmistat_o, 2'd0);
        capture_check("read_capture", 7'h11, 32'hDEAD_BEEF, 2'd0);

        // dmireset coinciding with a busy update: the clear wins.
        push_req(7'h12, 2'd1, 32'h0, 1'b0);
        do_update(7'h12, 32'h0, 2'd1);
        tick();
        dmireset_i = 1'b1;
        do_update(7'h22, 32'h5555_5555, 2'd2);
        dmireset_i = 1'b0;
        check("reset_beats_busy", dmistat_o, 2'd0);
        respond(32'h0000_1234, 2'd0);
        tick();

        // Busy: second update during WaitRead is dropped and sets dmistat=3.
        push_req(7'h05, 2'd1, 32'h0, 1'b0);
        do_update(7'h05, 32'h0, 2'd1);
        tick();
        do_update(7'h22, 32'h1111_1111, 2'd2);
        check("busy_dmistat", dmistat_o, 2'd3);
        respond(32'h1234_5678, 2'd0);
        check("busy_sticky_after_resp", dmistat_o, 2'd3);
        do_update(7'h23, 32'h2222_2222, 2'd2);
        tick(); tick();
        check("busy_ignored_update", dmistat_o, 2'd3);
        capture_check("busy_capture", 7'h05, 32'h1234_5678, 2'd3);
        pulse_dmireset();
        check("busy_cleared", dmistat_o, 2'd0);
        push_req(7'h07, 2'd2, 32'hA5A5_0F0F, 1'b1);
        do_update(7'h07, 32'hA5A5_0F0F, 2'd2);
        tick();
        respond(32'h0, 2'd0);
        check("post_clear_write_ok", dmistat_o, 2'd0);

        // Failed response: dmistat=2 sticky across three updates.
        push_req(7'h09, 2'd1, 32'h0, 1'b0);
        do_update(7'h09, 32'h0, 2'd1);
        tick();
        respond(32'hBAD0_0002, 2'd2);
        check("err_dmistat", dmistat_o, 2'd2);
        for (int i = 0; i < 3; i++) begin
            do_update(7'h30 + 7'(i), 32'h0000_0100 + 32'(i), (i == 1) ? 2'd2 : 2'd1);
            tick();
            check("err_sticky", dmistat_o, 2'd2);
        end
        pulse_dmireset();
        check("err_cleared", dmistat_o, 2'd0);

        // Hardreset while READ is stalled: valid drops, late response dropped.
        dmi_req_ready_i = 1'b0;
        push_req(7'h0A, 2'd1, 32'h0, 1'b0);
        do_update(7'h0A, 32'h0, 2'd1);
        tick();
        check("hr_valid_before", dmi_req_valid_o, 1'b1);
        dmihardreset_i = 1'b1;
        tick();
        dmihardreset_i = 1'b0;
        void'(exp_q.pop_front());
        check("hr_valid_dropped", dmi_req_valid_o, 1'b0);
        check("hr_dmistat", dmistat_o, 2'd0);
        check("hr_resp_ready", dmi_resp_ready_o, 1'b0);
        dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'hFFFF_FFFF; dmi_resp_resp_i = 2'd2;
        tick();
        dmi_resp_valid_i = 1'b0; dmi_resp_resp_i = 2'd0;
        check("hr_late_resp_dmistat", dmistat_o, 2'd0);
        tick(); tick();
        capture_check("hr_capture", 7'h0A, 32'hBAD0_0002, 2'd0);
        dmi_req_ready_i = 1'b1;

        // Async reset during WaitWrite, then a clean read of 0x04.
        push_req(7'h30, 2'd2, 32'h0000_00FF, 1'b1);
        do_update(7'h30, 32'h0000_00FF, 2'd2);
        tick();
        check("rst_in_wait_write", dmi_resp_ready_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("rst_valid", dmi_req_valid_o, 1'b0);
        check("rst_resp_ready", dmi_resp_ready_o, 1'b0);
        check("rst_dmistat", dmistat_o, 2'd0);
        check("rst_capture", capture_o, 64'h0);
        check("rst_req_fields", {dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}, 64'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        tick();
        push_req(7'h04, 2'd1, 32'h0, 1'b0);
        do_update(7'h04, 32'h0, 2'd1);
        tick();
        respond(32'hCAFE_F00D, 2'd0);
        tick(); tick();
        capture_check("post_rst_read_capture", 7'h04, 32'hCAFE_F00D, 2'd0);
        check("post_rst_dmistat", dmistat_o, 2'd0);

        tick(); tick();
        check("queue_drained", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_access_ctrl.md
Name: dmi_access_ctrl

Overview:
- DTM-side DMI access controller in the TCK domain, directly downstream of the JTAG shift logic that a host drives with DMIACCESS/DTMCSR scans.
- On each DMIACCESS Update-DR it turns the shifted 41-bit word into a valid/ready DMI request to the debug module and collects the response.
- It keeps the sticky busy/error status and supplies the Capture-DR word that the host reads back as {address, data, op}.

Parameters:
- AddrWidth, 7, DMI address width; DMI word width = AddrWidth+34 (41 by default).
- DmiIdleCycles, 3'd1, value reported in dtmcs.idle.

Ports:
- clk_i  in  1  TCK.
- rst_i  in  1  async active-high reset (TRST or power-on combined upstream).
- dmi_select_i  in  1  IR currently holds DMIACCESS.
- capture_dr_i  in  1  TAP in Capture-DR this cycle.
- update_dr_i  in  1  TAP in Update-DR this cycle.
- dr_i  in  AddrWidth+34  shifted DR word {addr, data[31:0], op[1:0]}.
- dmireset_i  in  1  dtmcs.dmireset write strobe.
- dmihardreset_i  in  1  dtmcs.dmihardreset write strobe.
- capture_o  out  AddrWidth+34  word loaded into shift register at Capture-DR.
- dmistat_o  out  2  dtmcs.dmistat.
- idle_o  out  3  dtmcs.idle (= DmiIdleCycles).
- dmi_req_valid_o  out  1  DMI request valid.
- dmi_req_ready_i  in  1  DM accepts request.
- dmi_req_addr_o  out  AddrWidth  request address.
- dmi_req_op_o  out  2  dm::dtm_op_e (DTM_READ/DTM_WRITE).
- dmi_req_data_o  out  32  write data.
- dmi_resp_valid_i  in  1  DM response valid.
- dmi_resp_ready_o  out  1  always 1 in WaitRead/WaitWrite, else 0.
- dmi_resp_data_i  in  32  read data.
- dmi_resp_resp_i  in  2  0 = ok, nonzero = failed.

Behaviour:
- Reset values: state Idle, dmi_req_valid_o=0, address/data regs 0, error 0 (DTM_SUCCESS), capture_o 0, dmistat_o 0.
- States: Idle, Read, WaitRead, Write, WaitWrite.
- Idle + update_dr_i + dmi_select_i + error==0:
  - op=DTM_READ: latch addr, go Read.
  - op=DTM_WRITE: latch addr and data, go Write.
  - op=DTM_NOP or 3: no action.
- Read/Write: dmi_req_valid_o=1 with the latched fields. Hold all fields stable until dmi_req_ready_i; then go WaitRead/WaitWrite. valid is never withdrawn before ready.
- WaitRead, on dmi_resp_valid_i: data reg <= dmi_resp_data_i; go Idle.
- WaitWrite, on dmi_resp_valid_i: go Idle; data reg is unchanged.
- In either Wait state, a nonzero dmi_resp_resp_i sets error=DTM_ERR (2) if error==0.
- Busy detection: update_dr_i or capture_dr_i with dmi_select_i while state≠Idle sets error=DTM_BUSY (3) if error==0. The update is dropped and the FSM continues undisturbed.
- Sticky error: once nonzero, it is held and new requests are ignored until dmireset_i. dmireset_i clears error in the same cycle. If dmireset_i and a busy event coincide, the clear wins.
- dmihardreset_i clears error and forces Idle with dmi_req_valid_o=0. An in-flight response arriving afterwards is dropped. Hardreset has priority over every other event.
- capture_o = {addr reg, data reg, error}, registered. Its value during Capture-DR reflects state at the previous edge, so one Capture-DR after a completed read returns that read's data.
- If a capture occurs while busy, the op field returned is 3 (busy is set combinationally into the captured op).
- dmistat_o = error. idle_o = DmiIdleCycles.
- Latency: Update-DR edge → dmi_req_valid_o high at the next edge (1 cycle). The minimum turnaround with ready=1 and a same-cycle response is 3 cycles back to Idle.
- Reset mid-transaction: all state clears asynchronously and dmi_req_valid_o drops immediately.

Decomposition:
- Use dm::dtm_op_e, dm::dtm_op_status_e and dm::dtmcs_t from the shared dm package.
- Add dm::dmi_req_t/dmi_resp_t there if not present.
- Local FSM state enum stays in the module.
- No sub-module. The TAP controller and shift register remain separate existing blocks.

Test Plan:
- Write addr 0x10 data 0x8000_0001 op WRITE, ready=1, resp ok next cycle → one request {0x10, 0x8000_0001, WRITE}; dmistat=0; next capture op=0.
- Read addr 0x11 with ready delayed 4 cycles, resp data 0xDEAD_BEEF → valid held 4 cycles with stable fields; next capture = {0x11, 0xDEAD_BEEF, 0}.
- Second update while in WaitRead → dmistat=3, no second request; further updates ignored; dmireset → dmistat=0 and the next write issues normally.
- Response with resp=2 → dmistat=2 sticky across 3 following updates (none issued) until dmireset.
- dmihardreset while in Read with ready=0 → valid drops the next cycle, state Idle, error 0; a late resp_valid is ignored.
- rst_i asserted mid-WaitWrite → all outputs 0 immediately; after release a read of addr 0x04 completes normally.
